battle_turn_engine: RTL and testbench
=====================================

Name: battle_turn_engine

Overview:
- Parametrised successor to the battle FSM/ALU pair: one block that runs a complete battle turn.
- A turn is player attack, then AI attack, with damage computed, HP tracked and the outcome detected.
- Damage is computed by an iterative shift-add multiplier shared by both sides, then scaled, optionally doubled on a critical hit, clamped to HP width, and subtracted from the defender's HP with saturation at zero.
- Sits between the move-select/input logic and the HP display/outcome logic.

Parameters:
- HP_W, 8, width of HP registers and of init_hp.
- PWR_W, 8, width of move power inputs.
- MULT_W, 4, width of attack multiplier inputs; also the multiplier iteration count.
- SHIFT, 2, right-shift applied to power*atk to form base damage.
- CNT_W, 8, width of the turn counter.

Ports:
- clk in 1: system clock, rising edge.
- resetn in 1: asynchronous active-low reset.
- start in 1: pulse; loads both HPs from init_hp and arms the battle.
- init_hp in HP_W: starting HP for both sides.
- go in 1: pulse; requests one turn.
- player_power in PWR_W: player move power.
- player_atk in MULT_W: player attack multiplier.
- player_crit in 1: player critical hit, doubles player damage.
- ai_power in PWR_W: AI move power.
- ai_atk in MULT_W: AI attack multiplier.
- ai_crit in 1: AI critical hit, doubles AI damage.
- player_hp out HP_W: player HP.
- ai_hp out HP_W: AI HP.
- busy out 1: high from go acceptance until turn end.
- turn_done out 1: one-cycle pulse when a turn completes with no winner.
- victory out 1: sticky; AI HP reached 0.
- loss out 1: sticky; player HP reached 0.
- turn_count out CNT_W: completed turns since start.

Behaviour:
- Reset (async, resetn=0):
  - State S_IDLE; armed=0.
  - All outputs 0: HPs, counters, flags, busy, turn_done.
  - Multiplier registers cleared.
  - Takes effect immediately, including mid-turn.
- States: S_IDLE, S_P_CALC, S_P_APPLY, S_A_CALC, S_A_APPLY, S_VICTORY, S_LOSS.
- start, sampled in any state, has priority over go:
  - player_hp and ai_hp <= init_hp; turn_count <= 0; victory and loss <= 0; armed <= 1; next state S_IDLE.
  - Any turn in progress is aborted and no HP is applied.
- go is accepted only in S_IDLE with armed=1; it is ignored otherwise, including while busy, in S_VICTORY/S_LOSS, or before the first start.
- On acceptance:
  - All power, atk and crit inputs are latched; later input changes have no effect on the turn.
  - busy=1 the next cycle.
- S_P_CALC: shift-add multiply latched player_power by player_atk, one multiplier bit per cycle, exactly MULT_W cycles.
- Damage formation, at the end of a CALC state:
  - prod = power*atk, PWR_W+MULT_W bits, exact.
  - dmg = prod >> SHIFT.
  - If crit, dmg <<= 1 with no loss of bits.
  - If dmg > 2^HP_W-1, dmg = 2^HP_W-1.
- S_P_APPLY (1 cycle): ai_hp <= (ai_hp > dmg) ? ai_hp-dmg : 0.
  - If the result is 0, go to S_VICTORY.
  - Otherwise go to S_A_CALC.
- S_A_CALC: same multiply on the AI operands, MULT_W cycles.
- S_A_APPLY (1 cycle): saturating subtract from player_hp.
  - If the result is 0, go to S_LOSS.
  - Otherwise turn_count++ (wraps modulo 2^CNT_W), turn_done pulses for one cycle, and the state returns to S_IDLE.
- Latency, go accepted to turn_done: 2*MULT_W+2 cycles (10 at defaults). busy deasserts in the same cycle turn_done pulses.
- Victory path:
  - victory=1 on the first cycle of S_VICTORY; busy=0 there.
  - The AI does not attack; player_hp is unchanged.
  - turn_count is not incremented.
- Loss path: mirrors the victory path with loss=1.
- S_VICTORY and S_LOSS are held until start or reset.
- Zero damage (power=0, atk=0, or prod<2^SHIFT) leaves HP unchanged; the turn still takes full latency.
- init_hp=0: the first go yields victory after S_P_APPLY, because the check is made after the apply.
- victory and loss are never both 1.

Test Plan:
- Defaults, start init_hp=100; go with player 40/4/0 and ai 20/4/0 -> 10 cycles later ai_hp=60, player_hp=80, turn_done pulse, turn_count=1, busy low.
- From ai_hp=30, go with player damage 40 -> after S_P_APPLY (cycle 5) ai_hp=0, victory=1; player_hp unchanged; no turn_done; turn_count unchanged.
- player_hp=10, player damage 1, ai 48/1/crit=1 (dmg 24) -> ai_hp decreases by 1, player_hp=0, loss=1, victory=0.
- player 255/15/crit=1 -> prod 3825, dmg 956, doubled 1912, clamped to 255; ai_hp=0 from any value, victory=1.
- go pulsed while busy and go before first start -> both ignored; start at cycle 3 of S_A_CALC -> HPs reloaded, S_IDLE, turn_count=0, no turn_done.
- resetn low mid-S_P_CALC, asynchronous to clk -> all outputs 0 immediately; after release, go is ignored until start.

Source files
------------

// File: rtl/battle_turn_engine.sv
// One battle turn: player attack, then AI attack, through a shared shift-add multiplier,
// with saturating HP updates, outcome detection and a turn counter.
module battle_turn_engine #(
    parameter int HP_W   = 8,
    parameter int PWR_W  = 8,
    parameter int MULT_W = 4,
    parameter int SHIFT  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [HP_W-1:0]   init_hp,
    input  logic              go,
    input  logic [PWR_W-1:0]  player_power,
    input  logic [MULT_W-1:0] player_atk,
    input  logic              player_crit,
    input  logic [PWR_W-1:0]  ai_power,
    input  logic [MULT_W-1:0] ai_atk,
    input  logic              ai_crit,
    output logic [HP_W-1:0]   player_hp,
    output logic [HP_W-1:0]   ai_hp,
    output logic              busy,
    output logic              turn_done,
    output logic              victory,
    output logic              loss,
    output logic [CNT_W-1:0]  turn_count
);

    localparam int PW = PWR_W + MULT_W;
    localparam int DW = PW + 1;
    localparam int WW = (DW > HP_W) ? DW : HP_W;
    localparam int IW = $clog2(MULT_W + 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(MULT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_P_CALC, S_P_APPLY, S_A_CALC, S_A_APPLY, S_VICTORY, S_LOSS
    } state_t;

    state_t            state_q;
    logic              armed_q;
    logic [HP_W-1:0]   player_hp_q, ai_hp_q;
    logic              busy_q, turn_done_q, victory_q, loss_q;
    logic [CNT_W-1:0]  turn_count_q;
    logic [PW-1:0]     mcand_q, acc_q;
    logic [MULT_W-1:0] mplier_q;
    logic [IW-1:0]     iter_q;
    logic              p_crit_q, a_crit_q;
    logic [PWR_W-1:0]  a_pow_q;
    logic [MULT_W-1:0] a_atk_q;

    logic              crit_d;
    logic [HP_W-1:0]   def_hp_d, dmg_d, hp_sub_d;
    logic [DW-1:0]     dmg_full_d;
    logic [WW-1:0]     dmg_wide_d;

    // Damage is formed from the finished product while sitting in an APPLY state.
    always_comb begin
        crit_d     = (state_q == S_A_APPLY) ? a_crit_q : p_crit_q;
        def_hp_d   = (state_q == S_A_APPLY) ? player_hp_q : ai_hp_q;
        dmg_full_d = {1'b0, acc_q} >> SHIFT;
        if (crit_d) begin
            dmg_full_d = dmg_full_d << 1;
        end
        dmg_wide_d = WW'(dmg_full_d);
        dmg_d      = (dmg_wide_d > WW'({HP_W{1'b1}})) ? '1 : dmg_wide_d[HP_W-1:0];
        hp_sub_d   = (def_hp_d > dmg_d) ? def_hp_d - dmg_d : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            armed_q      <= 1'b0;
            player_hp_q  <= '0;
            ai_hp_q      <= '0;
            busy_q       <= 1'b0;
            turn_done_q  <= 1'b0;
            victory_q    <= 1'b0;
            loss_q       <= 1'b0;
            turn_count_q <= '0;
            mcand_q      <= '0;
            acc_q        <= '0;
            mplier_q     <= '0;
            iter_q       <= '0;
            p_crit_q     <= 1'b0;
            a_crit_q     <= 1'b0;
            a_pow_q      <= '0;
            a_atk_q      <= '0;
        end else begin
            turn_done_q <= 1'b0;
            if (start) begin
                player_hp_q  <= init_hp;
                ai_hp_q      <= init_hp;
                turn_count_q <= '0;
                victory_q    <= 1'b0;
                loss_q       <= 1'b0;
                armed_q      <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (go && armed_q) begin
                            mcand_q  <= PW'(player_power);
                            mplier_q <= player_atk;
                            acc_q    <= '0;
                            iter_q   <= '0;
                            p_crit_q <= player_crit;
                            a_pow_q  <= ai_power;
                            a_atk_q  <= ai_atk;
                            a_crit_q <= ai_crit;
                            busy_q   <= 1'b1;
                            state_q  <= S_P_CALC;
                        end
                    end
                    S_P_CALC, S_A_CALC: begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        iter_q   <= iter_q + 1'b1;
                        if (iter_q == LAST_ITER) begin
                            state_q <= (state_q == S_P_CALC) ? S_P_APPLY : S_A_APPLY;
                        end
                    end
                    S_P_APPLY: begin
                        ai_hp_q <= hp_sub_d;
                        if (hp_sub_d == '0) begin
                            victory_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= S_VICTORY;
                        end else begin
                            mcand_q  <= PW'(a_pow_q);
                            mplier_q <= a_atk_q;
                            acc_q    <= '0;
                            iter_q   <= '0;
                            state_q  <= S_A_CALC;
                        end
                    end
                    S_A_APPLY: begin
                        player_hp_q <= hp_sub_d;
                        busy_q      <= 1'b0;
                        if (hp_sub_d == '0) begin
                            loss_q  <= 1'b1;
                            state_q <= S_LOSS;
                        end else begin
                            turn_count_q <= turn_count_q + 1'b1;
                            turn_done_q  <= 1'b1;
                            state_q      <= S_IDLE;
                        end
                    end
                    S_VICTORY, S_LOSS: begin
                        state_q <= state_q;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign player_hp  = player_hp_q;
    assign ai_hp      = ai_hp_q;
    assign busy       = busy_q;
    assign turn_done  = turn_done_q;
    assign victory    = victory_q;
    assign loss       = loss_q;
    assign turn_count = turn_count_q;

endmodule

// File: tb/tb_battle_turn_engine.sv
// Scoreboard bench for battle_turn_engine: directed turns push expected outcomes,
// a negedge monitor pops and compares on every turn_done / victory / loss event.
module tb_battle_turn_engine;

    logic       clk = 1'b0;
    logic       resetn, start, go;
    logic [7:0] init_hp, player_power, ai_power;
    logic [3:0] player_atk, ai_atk;
    logic       player_crit, ai_crit;
    logic [7:0] player_hp, ai_hp, turn_count;
    logic       busy, turn_done, victory, loss;

    battle_turn_engine #(.HP_W(8), .PWR_W(8), .MULT_W(4), .SHIFT(2), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .init_hp(init_hp), .go(go),
        .player_power(player_power), .player_atk(player_atk), .player_crit(player_crit),
        .ai_power(ai_power), .ai_atk(ai_atk), .ai_crit(ai_crit),
        .player_hp(player_hp), .ai_hp(ai_hp), .busy(busy), .turn_done(turn_done),
        .victory(victory), .loss(loss), .turn_count(turn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] php;
        logic [7:0] ahp;
        logic       vic;
        logic       los;
        logic [7:0] tc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   busy_hi_cnt = 0;
    int   lat_cnt = 0;
    logic busy_prev = 1'b0, vic_prev = 1'b0, loss_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ev;
        if (busy) busy_hi_cnt++;
        if (busy && !busy_prev) lat_cnt = 1;
        else if (busy) lat_cnt++;
        ev = turn_done || (victory && !vic_prev) || (loss && !loss_prev);
        if (ev) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_event: turn_done=%0d victory=%0d loss=%0d with nothing expected",
                         turn_done, victory, loss);
            end else begin
                e = sb.pop_front();
                chk({e.name, ".player_hp"}, 32'(player_hp), 32'(e.php));
                chk({e.name, ".ai_hp"}, 32'(ai_hp), 32'(e.ahp));
                chk({e.name, ".victory"}, 32'(victory), 32'(e.vic));
                chk({e.name, ".loss"}, 32'(loss), 32'(e.los));
                chk({e.name, ".turn_done"}, 32'(turn_done), 32'(!e.vic && !e.los));
                chk({e.name, ".turn_count"}, 32'(turn_count), 32'(e.tc));
                chk({e.name, ".busy"}, 32'(busy), 32'd0);
                chk({e.name, ".latency"}, 32'(lat_cnt), 32'(e.lat));
            end
        end
        busy_prev = busy;
        vic_prev  = victory;
        loss_prev = loss;
    end

    task automatic expect_ev(input string n, input logic [7:0] php, input logic [7:0] ahp,
                             input logic v, input logic l, input logic [7:0] tc, input int lat);
        exp_t e;
        e.name = n; e.php = php; e.ahp = ahp; e.vic = v; e.los = l; e.tc = tc; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic do_go(input logic [7:0] pp, input logic [3:0] pa, input logic pc,
                         input logic [7:0] ap, input logic [3:0] aa, input logic ac);
        @(negedge clk);
        player_power = pp; player_atk = pa; player_crit = pc;
        ai_power = ap; ai_atk = aa; ai_crit = ac;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        player_power = 8'($urandom); player_atk = 4'($urandom); player_crit = 1'($urandom);
        ai_power = 8'($urandom); ai_atk = 4'($urandom); ai_crit = 1'($urandom);
    endtask

    task automatic do_start(input logic [7:0] hp);
        @(negedge clk);
        start = 1'b1; init_hp = hp;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string n);
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        chk({n, ".drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int snap;
        resetn = 1'b1; start = 1'b0; go = 1'b0; init_hp = '0;
        player_power = '0; player_atk = '0; player_crit = 1'b0;
        ai_power = '0; ai_atk = '0; ai_crit = 1'b0;
        #2 resetn = 1'b0;
        #20;
        chk("reset.outputs", {player_hp, ai_hp, turn_count, busy, turn_done, victory, loss},
            32'd0);
        @(negedge clk); resetn = 1'b1;

        // go before any start must be ignored
        do_go(8'd40, 4'd4, 1'b0, 8'd20, 4'd4, 1'b0);
        idle(15);
        chk("pre_start.busy_cycles", 32'(busy_hi_cnt), 32'd0);
        chk("pre_start.ai_hp", 32'(ai_hp), 32'd0);

        do_start(8'd100);
        #1;
        chk("start.hps", {player_hp, ai_hp}, {16'd0, 8'd100, 8'd100});

        // 40*4>>2=40, 20*4>>2=20
        expect_ev("t1", 8'd80, 8'd60, 1'b0, 1'b0, 8'd1, 10);
        do_go(8'd40, 4'd4, 1'b0, 8'd20, 4'd4, 1'b0);
        drain("t1");

        // 8*4>>2=8; ai 4*4>>2=4, crit -> 8; extra go while busy is ignored
        expect_ev("t2", 8'd72, 8'd52, 1'b0, 1'b0, 8'd2, 10);
        do_go(8'd8, 4'd4, 1'b0, 8'd4, 4'd4, 1'b1);
        idle(3);
        go = 1'b1; @(negedge clk); go = 1'b0;
        drain("t2");
        snap = busy_hi_cnt;
        idle(15);
        chk("busy_go.extra_busy", 32'(busy_hi_cnt - snap), 32'd0);
        chk("busy_go.turn_count", 32'(turn_count), 32'd2);

        // zero damage: 3*1>>2=0, ai power 0 even with crit
        expect_ev("zero", 8'd72, 8'd52, 1'b0, 1'b0, 8'd3, 10);
        do_go(8'd3, 4'd1, 1'b0, 8'd0, 4'd15, 1'b1);
        drain("zero");

        // start during A_CALC aborts the turn
        do_go(8'd40, 4'd4, 1'b0, 8'd20, 4'd4, 1'b0);
        idle(7);
        start = 1'b1; init_hp = 8'd77;
        @(negedge clk); start = 1'b0;
        idle(15);
        chk("abort.hps", {player_hp, ai_hp}, {16'd0, 8'd77, 8'd77});
        chk("abort.turn_count", 32'(turn_count), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);

        // victory: ai 30, player dmg 40
        do_start(8'd30);
        expect_ev("victory", 8'd30, 8'd0, 1'b1, 1'b0, 8'd0, 5);
        do_go(8'd40, 4'd4, 1'b0, 8'd20, 4'd4, 1'b0);
        drain("victory");
        snap = busy_hi_cnt;
        do_go(8'd40, 4'd4, 1'b0, 8'd20, 4'd4, 1'b0);
        idle(15);
        chk("victory_hold.busy_cycles", 32'(busy_hi_cnt - snap), 32'd0);
        chk("victory_hold.flags", {victory, loss, player_hp}, {22'd0, 1'b1, 1'b0, 8'd30});

        // 255*15=3825 >>2=956, crit 1912, clamp 255
        do_start(8'd200);
        expect_ev("clamp", 8'd200, 8'd0, 1'b1, 1'b0, 8'd0, 5);
        do_go(8'd255, 4'd15, 1'b1, 8'd1, 4'd1, 1'b0);
        drain("clamp");

        // init_hp=0 wins after the first player apply
        do_start(8'd0);
        expect_ev("zero_hp", 8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 5);
        do_go(8'd0, 4'd0, 1'b0, 8'd0, 4'd0, 1'b0);
        drain("zero_hp");

        // loss: player dmg 4*1>>2=1; ai 48*1>>2=12, crit 24
        do_start(8'd10);
        expect_ev("loss", 8'd0, 8'd9, 1'b0, 1'b1, 8'd0, 10);
        do_go(8'd4, 4'd1, 1'b0, 8'd48, 4'd1, 1'b1);
        drain("loss");

        // async reset mid P_CALC
        do_start(8'd100);
        do_go(8'd40, 4'd4, 1'b0, 8'd20, 4'd4, 1'b0);
        @(posedge clk); @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("async_reset.outputs", {player_hp, ai_hp, turn_count, busy, turn_done, victory, loss},
            32'd0);
        @(negedge clk); resetn = 1'b1;
        snap = busy_hi_cnt;
        do_go(8'd40, 4'd4, 1'b0, 8'd20, 4'd4, 1'b0);
        idle(15);
        chk("post_reset.busy_cycles", 32'(busy_hi_cnt - snap), 32'd0);
        chk("post_reset.hps", {player_hp, ai_hp}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
